seg_display_driver: RTL

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

---
 rtl/seg_pkg.sv | 26 ++
 rtl/hex_to_seg.sv | 23 ++
 rtl/seg_display_driver.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared types and constants for the seven-segment display driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low glyphs, bit0 = segment a ... bit6 = segment g.
    localparam logic [6:0] HEX_GLYPH [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_seg
// Description : Combinational 4-bit digit to active-low 7-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] segments
);

    always_comb begin
        segments = HEX_GLYPH[digit];
        if (blank) begin
            segments = SEG_BLANK;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_driver
// Description : 4-digit multiplexed display with hex or double-dabble decimal.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_driver
    import seg_pkg::*;
#(
    parameter int RefreshCount = 50000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Value,
    input  logic        Load,
    input  logic        DecimalMode,
    output logic        Busy,
    output logic        Overflow,
    output logic [6:0]  Segments,
    output logic [3:0]  Anodes
);

    localparam int CNT_W = (RefreshCount > 1) ? $clog2(RefreshCount) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RefreshCount - 1);

    state_t            state;
    state_t            state_next;
    logic [3:0]        conv_cnt;
    logic [15:0]       shift_reg;
    logic [19:0]       bcd;
    logic [15:0]       bcd_adj;
    logic [3:0][3:0]   digits;
    logic [3:0]        blank;
    logic [3:0]        commit_blank;
    logic              bcd_ovf;
    logic              zero3;
    logic              zero2;
    logic              zero1;
    logic              load_ok;
    logic [CNT_W-1:0]  refresh_cnt;
    logic [1:0]        index;
    logic [6:0]        glyph;

    assign load_ok = Load && (state == IDLE);
    assign Busy    = (state != IDLE);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_ok && DecimalMode) state_next = CONVERT;
            CONVERT: if (conv_cnt == 4'd15) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Digit 4 never reaches 5 before the final shift of a 16-bit input, so it needs no adjust.
    always_comb begin
        bcd_adj = bcd[15:0];
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_ovf      = (bcd[19:16] != 4'd0);
    assign zero3        = (bcd[15:12] == 4'd0);
    assign zero2        = (bcd[11:8]  == 4'd0);
    assign zero1        = (bcd[7:4]   == 4'd0);
    assign commit_blank = bcd_ovf ? 4'b0000
                                  : {zero3, zero3 & zero2, zero3 & zero2 & zero1, 1'b0};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            conv_cnt  <= '0;
            shift_reg <= '0;
            bcd       <= '0;
            digits    <= '0;
            blank     <= '0;
            Overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_ok && DecimalMode) begin
                        shift_reg <= Value;
                        bcd       <= '0;
                        conv_cnt  <= '0;
                    end else if (load_ok) begin
                        digits   <= Value;
                        blank    <= '0;
                        Overflow <= 1'b0;
                    end
                end
                CONVERT: begin
                    {bcd, shift_reg} <= {bcd[18:16], bcd_adj, shift_reg, 1'b0};
                    conv_cnt         <= conv_cnt + 4'd1;
                end
                COMMIT: begin
                    digits   <= bcd[15:0];
                    blank    <= commit_blank;
                    Overflow <= bcd_ovf;
                end
                default: begin
                end
            endcase
        end
    end

    hex_to_seg u_glyph (
        .digit    (digits[index]),
        .blank    (blank[index]),
        .segments (glyph)
    );

    // Anodes and Segments are both registered from the same index so they never disagree.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            refresh_cnt <= '0;
            index       <= 2'd0;
            Anodes      <= 4'b1110;
            Segments    <= HEX_GLYPH[0];
        end else begin
            if (refresh_cnt == CNT_LAST) begin
                refresh_cnt <= '0;
                index       <= index + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + CNT_W'(1);
            end
            Anodes   <= ~(4'b0001 << index);
            Segments <= glyph;
        end
    end

endmodule
`default_nettype wire
